// File: rtl/sram_stream_fifo.sv
// sram_stream_fifo: turns a 1RW + 1R dual-port SRAM macro into a valid/ready
// stream FIFO. Words are written through port 0 and prefetched through port 1
// into a 2-entry registered output buffer. Capacity is DEPTH + 2 words, and
// the FIFO moves one word in and one word out per cycle.
//
// Handshake: a transfer happens on a rising clk edge where valid && ready.
// valid never waits for ready. Once valid is high, it and its data hold
// until the transfer. s_ready does not depend on s_valid. m_valid does not
// depend on m_ready.
module sram_stream_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_WMASKS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [ADDR_WIDTH+1:0] level,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  output logic                  sram_csb1,
  output logic [ADDR_WIDTH-1:0] sram_addr1,
  input  logic [DATA_WIDTH-1:0] sram_dout1
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [CW-1:0]         sram_cnt;   // words in SRAM whose read is not yet issued
  logic                  inflight;   // read issued last cycle, data arrives this cycle
  logic [1:0]            out_cnt;    // words held in the output buffer
  logic [DATA_WIDTH-1:0] buf_head;
  logic [DATA_WIDTH-1:0] buf_tail;

  logic                  push;
  logic                  pop;
  logic                  issue;
  logic [2:0]            occ;

  // Stream-side handshake terms.
  assign s_ready = (sram_cnt != CW'(DEPTH)) && !clear;
  assign push    = s_valid && s_ready;
  assign m_valid = (out_cnt != 2'd0);
  assign pop     = m_valid && m_ready;
  assign m_data  = buf_head;

  // A read is issued only when the buffer can hold its data next cycle.
  // "out_cnt + inflight - pop < 2" is rewritten as "occ < 2 + pop" so that
  // no unsigned subtraction is needed.
  assign occ   = {1'b0, out_cnt} + {2'b00, inflight};
  assign issue = (sram_cnt != '0) && (occ < (3'd2 + {2'b00, pop})) && !clear;

  // Port 0 is used only for writes. Port 1 is used only for reads.
  assign sram_csb0   = !push;
  assign sram_web0   = !push;
  assign sram_wmask0 = '1;
  assign sram_addr0  = wr_ptr;
  assign sram_din0   = s_data;
  assign sram_csb1   = !issue;
  assign sram_addr1  = rd_ptr;

  assign level = {1'b0, sram_cnt}
               + {{(ADDR_WIDTH+1){1'b0}}, inflight}
               + {{ADDR_WIDTH{1'b0}}, out_cnt};

  // Pointer, SRAM occupancy and read-in-flight tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      sram_cnt <= '0;
      inflight <= 1'b0;
    end else if (clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      sram_cnt <= '0;
      inflight <= 1'b0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (issue) rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      case ({push, issue})
        2'b10:   sram_cnt <= sram_cnt + CW'(1);
        2'b01:   sram_cnt <= sram_cnt - CW'(1);
        default: sram_cnt <= sram_cnt;
      endcase
      inflight <= issue;
    end
  end

  // Output buffer: capture returning read data at the tail, shift on pop.
  // The issue gate guarantees that a capture never arrives with two words
  // already held and no pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_cnt  <= 2'd0;
      buf_head <= '0;
      buf_tail <= '0;
    end else if (clear) begin
      out_cnt  <= 2'd0;
    end else begin
      case ({inflight, pop})
        2'b10: begin
          if (out_cnt == 2'd0) buf_head <= sram_dout1;
          else                 buf_tail <= sram_dout1;
          out_cnt <= out_cnt + 2'd1;
        end
        2'b01: begin
          if (out_cnt == 2'd2) buf_head <= buf_tail;
          out_cnt <= out_cnt - 2'd1;
        end
        2'b11: begin
          if (out_cnt == 2'd2) begin
            buf_head <= buf_tail;
            buf_tail <= sram_dout1;
          end else begin
            buf_head <= sram_dout1;
          end
        end
        default: out_cnt <= out_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_stream_fifo.sv
// tb_sram_stream_fifo: directed bench for sram_stream_fifo with a behavioural
// dual-port SRAM and a queue scoreboard.
module tb_sram_stream_fifo;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam int NW = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          clear;
  logic [DW-1:0] s_data;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic [AW+1:0] level;
  logic          sram_csb0;
  logic          sram_web0;
  logic [NW-1:0] sram_wmask0;
  logic [AW-1:0] sram_addr0;
  logic [DW-1:0] sram_din0;
  logic          sram_csb1;
  logic [AW-1:0] sram_addr1;
  logic [DW-1:0] sram_dout1;

  sram_stream_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_WMASKS(NW)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .level(level),
    .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
    .sram_addr0(sram_addr0), .sram_din0(sram_din0),
    .sram_csb1(sram_csb1), .sram_addr1(sram_addr1), .sram_dout1(sram_dout1)
  );

  // ---------------- SRAM model ----------------
  // Requests are latched at posedge. The write and read happen at the
  // following negedge. Read data goes to X shortly after the next posedge.
  logic [DW-1:0] mem [1 << AW];
  logic          nxt_w = 1'b0, nxt_r = 1'b0, lat_w = 1'b0, lat_r = 1'b0;
  logic [AW-1:0] nxt_wa = '0, nxt_ra = '0, lat_wa = '0, lat_ra = '0;
  logic [DW-1:0] nxt_wd = '0, lat_wd = '0;

  always begin
    @(negedge clk);
    if (lat_w) mem[lat_wa] = lat_wd;
    if (lat_r) sram_dout1 = mem[lat_ra];
    nxt_w  = !sram_csb0 && !sram_web0;
    nxt_wa = sram_addr0;
    nxt_wd = sram_din0;
    nxt_r  = !sram_csb1;
    nxt_ra = sram_addr1;
    @(posedge clk);
    lat_w  = nxt_w;
    lat_wa = nxt_wa;
    lat_wd = nxt_wd;
    lat_r  = nxt_r;
    lat_ra = nxt_ra;
    #1 sram_dout1 = 'x;
  end

  // ---------------- scoreboard ----------------
  int            pass_cnt = 0;
  int            chk_cnt  = 0;
  logic [DW-1:0] exp_q[$];
  int            pop_total = 0;
  logic          hold = 1'b0;
  logic [DW-1:0] held;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Monitor: record pushes, compare pops, check head stability and port collisions.
  always @(negedge clk) begin
    if (rst_n) begin
      if (hold) check("hold_stable", {31'd0, m_valid, m_data}, {31'd0, 1'b1, held});
      hold = m_valid && !m_ready && !clear;
      held = m_data;
      if (!sram_csb0 && !sram_web0 && !sram_csb1)
        check("port_collision", {63'd0, sram_addr0 == sram_addr1}, 64'd0);
      if (s_valid && s_ready) exp_q.push_back(s_data);
      if (m_valid && m_ready) begin
        pop_total++;
        check("pop_queue_nonempty", {63'd0, exp_q.size() != 0}, 64'd1);
        if (exp_q.size() != 0) check("pop_data", 64'(m_data), 64'(exp_q.pop_front()));
      end
    end else begin
      hold = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag, input int n_exp);
    int  base;
    bit  done;
    base = pop_total;
    done = 1'b0;
    m_ready = 1'b1;
    for (int c = 0; c < 2000 && !done; c++) begin
      @(negedge clk);
      if (level == 0 && !m_valid) done = 1'b1;
      tick();
    end
    m_ready = 1'b0;
    check({tag, "_drain_done"}, 64'(done), 64'd1);
    check({tag, "_drain_count"}, 64'(pop_total - base), 64'(n_exp));
    check({tag, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  // Leaves the FIFO with level 5 and a read in flight. Returns at posedge+1.
  task automatic setup_inflight(input string tag);
    m_ready = 1'b0;
    s_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      s_data = $urandom;
      @(negedge clk);
      tick();
    end
    s_valid = 1'b0;
    repeat (4) begin
      @(negedge clk);
      tick();
    end
    @(negedge clk);
    check({tag, "_level6"}, 64'(level), 64'd6);
    tick();
    m_ready = 1'b1;
    @(negedge clk);
    tick();
    m_ready = 1'b0;
  endtask

  task automatic a5_tail(input string tag);
    bit got;
    s_valid = 1'b1;
    s_data  = 32'hA5A5_A5A5;
    @(negedge clk);
    tick();
    s_valid = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk);
      if (m_valid) got = 1'b1;
      else tick();
    end
    check({tag, "_a5_seen"}, 64'(got), 64'd1);
    check({tag, "_a5_data"}, 64'(m_data), 64'hA5A5_A5A5);
    check({tag, "_a5_level"}, 64'(level), 64'd1);
    tick();
    m_ready = 1'b1;
    @(negedge clk);
    tick();
    m_ready = 1'b0;
    @(negedge clk);
    check({tag, "_a5_empty"}, 64'(level), 64'd0);
    tick();
  endtask

  // ---------------- directed sequence ----------------
  int acc, sent, base, bubbles, badlvl;
  bit started;

  initial begin
    rst_n = 1'b0; clear = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset values
    @(negedge clk);
    check("rst_s_ready", 64'(s_ready), 64'd1);
    check("rst_m_valid", 64'(m_valid), 64'd0);
    check("rst_m_data",  64'(m_data),  64'd0);
    check("rst_level",   64'(level),   64'd0);
    check("rst_csb0",    64'(sram_csb0), 64'd1);
    check("rst_web0",    64'(sram_web0), 64'd1);
    check("rst_csb1",    64'(sram_csb1), 64'd1);
    tick();

    // Single word fall-through
    s_valid = 1'b1;
    s_data  = 32'hDEAD_BEEF;
    @(negedge clk);
    check("sw_csb0",  64'(sram_csb0),  64'd0);
    check("sw_web0",  64'(sram_web0),  64'd0);
    check("sw_addr0", 64'(sram_addr0), 64'd0);
    check("sw_din0",  64'(sram_din0),  64'hDEAD_BEEF);
    check("sw_wmask", 64'(sram_wmask0), 64'hF);
    check("sw_csb1_idle", 64'(sram_csb1), 64'd1);
    tick();
    s_valid = 1'b0;
    @(negedge clk);
    check("sw_csb1",  64'(sram_csb1),  64'd0);
    check("sw_addr1", 64'(sram_addr1), 64'd0);
    check("sw_level_a", 64'(level), 64'd1);
    check("sw_mvalid_a", 64'(m_valid), 64'd0);
    tick();
    @(negedge clk);
    check("sw_mvalid_b", 64'(m_valid), 64'd0);
    check("sw_level_b", 64'(level), 64'd1);
    tick();
    @(negedge clk);
    check("sw_mvalid_c", 64'(m_valid), 64'd1);
    check("sw_mdata",    64'(m_data), 64'hDEAD_BEEF);
    check("sw_level_c",  64'(level), 64'd1);
    tick();
    m_ready = 1'b1;
    @(negedge clk);
    tick();
    m_ready = 1'b0;
    @(negedge clk);
    check("sw_level_d", 64'(level), 64'd0);
    check("sw_mvalid_d", 64'(m_valid), 64'd0);
    tick();

    // Fill until stall, then drain in order
    s_valid = 1'b1;
    acc = 0;
    s_data = '0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (s_ready) acc++;
      tick();
      s_data = 32'(acc);
    end
    s_valid = 1'b0;
    @(negedge clk);
    check("fill_accepted", 64'(acc), 64'd258);
    check("fill_s_ready",  64'(s_ready), 64'd0);
    check("fill_level",    64'(level), 64'd258);
    check("fill_m_data",   64'(m_data), 64'd0);
    tick();
    drain("fill", 258);

    // Streaming: one word per cycle in and out
    s_valid = 1'b1;
    m_ready = 1'b1;
    sent = 0; base = pop_total; started = 1'b0; bubbles = 0; badlvl = 0;
    s_data = 32'h1000_0000;
    for (int c = 0; c < 1200 && (pop_total - base) < 1000; c++) begin
      @(negedge clk);
      if (m_valid) started = 1'b1;
      if (started && !m_valid) bubbles++;
      if (started && s_valid && !(level == 2 || level == 3)) badlvl++;
      if (s_valid && s_ready) sent++;
      tick();
      if (sent == 1000) s_valid = 1'b0;
      s_data = 32'h1000_0000 + 32'(sent);
    end
    s_valid = 1'b0;
    m_ready = 1'b0;
    check("stream_sent",    64'(sent), 64'd1000);
    check("stream_popped",  64'(pop_total - base), 64'd1000);
    check("stream_bubbles", 64'(bubbles), 64'd0);
    check("stream_level",   64'(badlvl), 64'd0);
    check("stream_queue_empty", 64'(exp_q.size()), 64'd0);

    // Wrap-around with random output backpressure
    sent = 0; base = pop_total;
    for (int c = 0; c < 4000 && (pop_total - base) < 600; c++) begin
      m_ready = 1'($urandom_range(0, 1));
      s_valid = (sent < 600);
      s_data  = $urandom;
      @(negedge clk);
      if (s_valid && s_ready) sent++;
      tick();
    end
    s_valid = 1'b0;
    m_ready = 1'b0;
    check("wrap_sent",   64'(sent), 64'd600);
    check("wrap_popped", 64'(pop_total - base), 64'd600);
    check("wrap_queue_empty", 64'(exp_q.size()), 64'd0);

    // Toggling m_ready with input stalling every third cycle
    sent = 0; base = pop_total;
    for (int c = 0; c < 3000 && (pop_total - base) < 300; c++) begin
      m_ready = c[0];
      s_valid = ((c % 3) != 2) && (sent < 300);
      s_data  = $urandom;
      @(negedge clk);
      if (s_valid && s_ready) sent++;
      tick();
    end
    s_valid = 1'b0;
    m_ready = 1'b0;
    check("bp_sent",   64'(sent), 64'd300);
    check("bp_popped", 64'(pop_total - base), 64'd300);
    check("bp_queue_empty", 64'(exp_q.size()), 64'd0);

    // Clear with a read in flight
    setup_inflight("clr");
    clear   = 1'b1;
    s_valid = 1'b1;
    s_data  = 32'h1234_5678;
    @(negedge clk);
    check("clr_level5",  64'(level), 64'd5);
    check("clr_s_ready", 64'(s_ready), 64'd0);
    check("clr_csb0",    64'(sram_csb0), 64'd1);
    check("clr_csb1",    64'(sram_csb1), 64'd1);
    check("clr_m_valid_before", 64'(m_valid), 64'd1);
    exp_q.delete();
    tick();
    clear   = 1'b0;
    s_valid = 1'b0;
    @(negedge clk);
    check("clr_level0",  64'(level), 64'd0);
    check("clr_m_valid", 64'(m_valid), 64'd0);
    check("clr_csb1_after", 64'(sram_csb1), 64'd1);
    tick();
    a5_tail("clr");

    // Asynchronous reset with a read in flight
    setup_inflight("rst");
    rst_n = 1'b0;
    #2;
    check("arst_level",   64'(level), 64'd0);
    check("arst_m_valid", 64'(m_valid), 64'd0);
    check("arst_csb0",    64'(sram_csb0), 64'd1);
    check("arst_csb1",    64'(sram_csb1), 64'd1);
    rst_n = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("arst_level_a",   64'(level), 64'd0);
    check("arst_m_valid_a", 64'(m_valid), 64'd0);
    tick();
    @(negedge clk);
    check("arst_level_b",   64'(level), 64'd0);
    check("arst_m_valid_b", 64'(m_valid), 64'd0);
    tick();
    a5_tail("rst");

    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
